// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: register map, FSM states,
// source-count limit and vector width.
package irq_pkg;

    localparam int MAX_SRC = 8;
    localparam int VEC_W   = 3;

    localparam logic [7:0] IRQ_PEND_ADDR = 8'h3A;
    localparam logic [7:0] IRQ_CTRL_ADDR = 8'h3B;
    localparam logic [7:0] IRQ_MASK_ADDR = 8'h3C;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

endpackage

// File: rtl/irq_prio_pick.sv
// Combinational winner search over the eligible vector, starting at base
// and wrapping. Ports: elig, base in; win, valid out.
module irq_prio_pick
    import irq_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] elig,
    input  logic [VEC_W-1:0] base,
    output logic [VEC_W-1:0] win,
    output logic             valid
);

    // Rotate so that bit 0 of rot is the source at index base.
    logic [N_SRC-1:0] rot;

    assign rot = N_SRC'({elig, elig} >> base);

    always_comb begin
        win   = '0;
        valid = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!valid && rot[k]) begin
                valid = 1'b1;
                win   = VEC_W'((int'(base) + k) % N_SRC);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Shares one CPU interrupt line among N_SRC timers: edge capture into
// pending bits, masking, a two-state grant FSM and a register bus.
// Ports: clk, rst_n, addr/wdata/write/read/rdata bus, src_req/src_ack to
// timers, cpu_irq/cpu_vec/cpu_ack to the CPU.
// Build option: define IRQ_RR_EN for round-robin instead of fixed priority.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int         N_SRC     = 4,
    parameter logic [7:0] CTRL_ADDR = IRQ_CTRL_ADDR,
    parameter logic [7:0] MASK_ADDR = IRQ_MASK_ADDR,
    parameter logic [7:0] PEND_ADDR = IRQ_PEND_ADDR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       addr,
    input  logic [7:0]       wdata,
    input  logic             write,
    input  logic             read,
    output logic [7:0]       rdata,
    input  logic [N_SRC-1:0] src_req,
    output logic [N_SRC-1:0] src_ack,
    output logic             cpu_irq,
    output logic [VEC_W-1:0] cpu_vec,
    input  logic             cpu_ack
);

    state_t           state_q, state_d;
    logic             gie_q, gie_d;
    logic             irq_q, irq_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] req_q;
    logic [N_SRC-1:0] ack_q, ack_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [VEC_W-1:0] vec_q, vec_d;

    logic [N_SRC-1:0] elig, rise, clr, vec_oh;
    logic [VEC_W-1:0] base, win;
    logic             win_vld;
    logic             wr_ctrl, wr_mask, wr_pend, take_ack;
    logic [7:0]       mask_ext, pend_ext;
    logic             unused_wdata;

    assign unused_wdata = ^wdata;

    assign wr_ctrl  = write && (addr == CTRL_ADDR);
    assign wr_mask  = write && (addr == MASK_ADDR);
    assign wr_pend  = write && (addr == PEND_ADDR);
    assign take_ack = (state_q == GRANT) && cpu_ack;

    assign rise = src_req & ~req_q;
    assign elig = pend_q & mask_q & {N_SRC{gie_q}};

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            vec_oh[i] = (int'(vec_q) == i);
        end
    end

`ifdef IRQ_RR_EN
    logic [VEC_W-1:0] ptr_q, ptr_d;

    // Search starts just after the last granted source.
    always_comb begin
        ptr_d = take_ack ? vec_q : ptr_q;
        base  = (int'(ptr_q) >= N_SRC - 1) ? '0 : ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    assign base = '0;
`endif

    irq_prio_pick #(
        .N_SRC (N_SRC)
    ) u_pick (
        .elig  (elig),
        .base  (base),
        .win   (win),
        .valid (win_vld)
    );

    // A new edge wins over any clear of the same bit.
    always_comb begin
        gie_d  = gie_q;
        mask_d = mask_q;
        clr    = '0;
        if (wr_ctrl) begin
            gie_d = wdata[0];
            if (wdata[1]) clr = '1;
        end
        if (wr_mask)  mask_d = wdata[N_SRC-1:0];
        if (wr_pend)  clr    = clr | wdata[N_SRC-1:0];
        if (take_ack) clr    = clr | vec_oh;
        pend_d = (pend_q & ~clr) | rise;
    end

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        vec_d   = vec_q;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = GRANT;
                    irq_d   = 1'b1;
                    vec_d   = win;
                end
            end
            GRANT: begin
                if (cpu_ack) begin
                    ack_d   = vec_oh;
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end else if (!gie_q) begin
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        mask_ext              = '0;
        pend_ext              = '0;
        mask_ext[N_SRC-1:0]   = mask_q;
        pend_ext[N_SRC-1:0]   = pend_q;
        rdata_d               = rdata_q;
        if (read && !write) begin
            case (addr)
                CTRL_ADDR: rdata_d = {7'b0, gie_q};
                MASK_ADDR: rdata_d = mask_ext;
                PEND_ADDR: rdata_d = pend_ext;
                default:   rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gie_q   <= 1'b0;
            irq_q   <= 1'b0;
            mask_q  <= '0;
            pend_q  <= '0;
            req_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            gie_q   <= gie_d;
            irq_q   <= irq_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            req_q   <= src_req;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            vec_q   <= vec_d;
        end
    end

    assign rdata   = rdata_q;
    assign src_ack = ack_q;
    assign cpu_irq = irq_q;
    assign cpu_vec = vec_q;

endmodule
